// File: rtl/ser_word_if.sv
// Parallel word handshake between an upstream producer and the serializer
// tree scheduler. A word transfers on a clock edge where valid & ready.
//   data   W bits  parallel word, bit0 is serialized first
//   valid  1       data holds a word to transfer
//   ready  1       consumer can take a word this cycle
interface ser_word_if #(
    parameter int W = 4
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ser_tree_scheduler.sv
// Word scheduler for the clock-divider / base-serializer tree.
// Runs on the fast serial clock, buffers incoming parallel words in a small
// FIFO and hands one SER_W-bit word to the tree leaves every SER_W cycles.
// After enable or a retrain request it sends a burst of TRAIN_WORDS training
// words; when the buffer runs dry in RUN it inserts IDLE_PAT and counts it.
// Ports:
//   clk_i        fast serial clock (tree root clock)
//   rst_i        synchronous active-high reset
//   en_i         link enable, acted on at word boundaries (any cycle in OFF)
//   train_i      retrain request level, sampled at word boundaries
//   in_if        slave side of the upstream word handshake
//   par_o        word presented to the serializer leaves
//   load_o       one-cycle pulse; par_o changes on the edge that ends it
//   state_o      0=OFF 1=TRAIN 2=RUN
//   level_o      FIFO occupancy
//   underflow_o  saturating count of idle words inserted in RUN
module ser_tree_scheduler #(
    parameter int LEVELS      = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TRAIN_WORDS = 8,
    localparam int SER_W      = 2 ** LEVELS,
    parameter logic [SER_W-1:0] TRAIN_PAT = 4'b1010,
    parameter logic [SER_W-1:0] IDLE_PAT  = 4'b0000
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            en_i,
    input  logic                            train_i,
    ser_word_if.slave                       in_if,
    output logic [SER_W-1:0]                par_o,
    output logic                            load_o,
    output logic [1:0]                      state_o,
    output logic [$clog2(FIFO_DEPTH):0]     level_o,
    output logic [7:0]                      underflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TC_W  = $clog2(TRAIN_WORDS + 1);

    localparam logic [LEVELS-1:0] CNT_LAST = LEVELS'(SER_W - 1);
    localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [TC_W-1:0]   TC_LAST  = TC_W'(TRAIN_WORDS - 1);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_TRAIN = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [LEVELS-1:0] cnt_q;
    logic [TC_W-1:0]   tcnt_q, tcnt_d;
    logic [SER_W-1:0]  par_q, par_d;
    logic [7:0]        uflow_q;

    logic [SER_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;

    logic boundary, push, pop, flush, idle_ins, ready;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The edge that ends the last phase of a word is the word boundary.
    assign boundary = (state_q != S_OFF) && (cnt_q == CNT_LAST);
    assign ready    = (state_q != S_OFF) && (level_q != LVL_FULL);
    assign push     = in_if.valid && ready;

    // Boundary decisions: disable beats retrain beats normal word flow.
    // Pop uses the registered level, so a word arriving this cycle is never
    // forwarded straight to par_o.
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        par_d    = par_q;
        pop      = 1'b0;
        flush    = 1'b0;
        idle_ins = 1'b0;
        unique case (state_q)
            S_OFF: begin
                flush = 1'b1;
                if (en_i) begin
                    state_d = S_TRAIN;
                    tcnt_d  = '0;
                end
            end
            S_TRAIN: begin
                if (boundary) begin
                    if (!en_i) begin
                        state_d = S_OFF;
                        par_d   = IDLE_PAT;
                        flush   = 1'b1;
                    end else begin
                        par_d  = TRAIN_PAT;
                        tcnt_d = tcnt_q + TC_W'(1);
                        if (tcnt_q == TC_LAST) state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (boundary) begin
                    if (!en_i) begin
                        state_d = S_OFF;
                        par_d   = IDLE_PAT;
                        flush   = 1'b1;
                    end else if (train_i) begin
                        // The retrain boundary itself carries training word 1.
                        par_d   = TRAIN_PAT;
                        tcnt_d  = TC_W'(1);
                        state_d = (TRAIN_WORDS == 1) ? S_RUN : S_TRAIN;
                    end else if (level_q != '0) begin
                        par_d = mem[rd_ptr_q];
                        pop   = 1'b1;
                    end else begin
                        par_d    = IDLE_PAT;
                        idle_ins = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_OFF;
                flush   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_OFF;
        else       state_q <= state_d;
    end

    // Phase counter, training count, output word and underflow counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            tcnt_q  <= '0;
            par_q   <= IDLE_PAT;
            uflow_q <= 8'd0;
        end else begin
            cnt_q  <= (state_q == S_OFF) ? '0 : cnt_q + LEVELS'(1);
            tcnt_q <= tcnt_d;
            par_q  <= par_d;
            if (idle_ins) uflow_q <= sat_inc8(uflow_q);
        end
    end

    // FIFO control; flush wins over a push arriving on the disabling edge.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FIFO storage carries no reset; occupancy alone defines valid entries.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= in_if.data;
    end

    assign in_if.ready = ready;
    assign par_o       = par_q;
    assign load_o      = boundary;
    assign state_o     = state_q;
    assign level_o     = level_q;
    assign underflow_o = uflow_q;
endmodule
